// File: rtl/vga_pkg.sv
// vga_pkg: shared widths, defaults and config FSM state type
package vga_pkg;
  localparam int VGA_ADDR_W = 19;
  localparam int VGA_DATA_W = 8;
  localparam int VGA_DIM_W = 16;
  localparam int VGA_WAIT_W = 8;
  localparam int VGA_DEF_DIM = 400;
  typedef enum logic {CFG_ACTIVE, CFG_PENDING} cfg_state_t;
endpackage

// File: rtl/vga_cfg_shadow.sv
// vga_cfg_shadow: pending/active config registers committed only on frame_start
module vga_cfg_shadow
  import vga_pkg::*;
#(
  parameter int DIM_W = VGA_DIM_W,
  parameter int DEF_DIM = VGA_DEF_DIM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             cfg_load,
  input  logic [DIM_W-1:0] cfg_dim,
  input  logic             cfg_interp,
  output logic [DIM_W-1:0] dim_out,
  output logic             interp_out,
  output logic             cfg_pending
);
  cfg_state_t state, state_nxt;
  logic [DIM_W-1:0] pend_dim;
  logic pend_interp;
  logic commit;
  always_comb begin
    commit = (state == CFG_PENDING) && frame_start;
    state_nxt = state == CFG_ACTIVE ? (cfg_load ? CFG_PENDING : CFG_ACTIVE)
                                    : (frame_start && !cfg_load ? CFG_ACTIVE : CFG_PENDING);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CFG_ACTIVE;
      pend_dim <= DIM_W'(DEF_DIM);
      pend_interp <= 1'b0;
      dim_out <= DIM_W'(DEF_DIM);
      interp_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cfg_load) begin
        pend_dim <= cfg_dim;
        pend_interp <= cfg_interp;
      end
      if (commit) begin
        dim_out <= pend_dim;
        interp_out <= pend_interp;
      end
    end
  end
  assign cfg_pending = (state == CFG_PENDING);
endmodule

// File: rtl/vga_frame_ctrl.sv
// vga_frame_ctrl: VGA-priority RAM arbiter, read return, CPU wait stats, frame-synced config
module vga_frame_ctrl
  import vga_pkg::*;
#(
  parameter int ADDR_W = VGA_ADDR_W,
  parameter int DATA_W = VGA_DATA_W,
  parameter int DIM_W = VGA_DIM_W,
  parameter int DEF_DIM = VGA_DEF_DIM,
  parameter int WAIT_W = VGA_WAIT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              cfg_load,
  input  logic [DIM_W-1:0]  cfg_dim,
  input  logic              cfg_interp,
  output logic [DIM_W-1:0]  dim_out,
  output logic              interp_out,
  output logic              cfg_pending,
  input  logic              vga_en,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stat_clr,
  output logic [WAIT_W-1:0] cpu_wait_max
);
  logic [ADDR_W-1:0] addr_q;
  logic [WAIT_W-1:0] wait_cnt;
  always_comb begin
    cpu_gnt = !vga_en && cpu_req;
    mem_addr = vga_en ? vga_addr : cpu_req ? cpu_addr : addr_q;
    mem_we = cpu_gnt && cpu_we;
    mem_wdata = cpu_wdata;
  end
  assign vga_rdata = mem_rdata;
  assign cpu_rdata = mem_rdata;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      vga_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      wait_cnt <= '0;
      cpu_wait_max <= '0;
    end else begin
      addr_q <= mem_addr;
      vga_rvalid <= vga_en;
      cpu_rvalid <= cpu_gnt && !cpu_we;
      wait_cnt <= stat_clr || !cpu_req || cpu_gnt ? '0 : &wait_cnt ? wait_cnt : wait_cnt + 1'b1;
      cpu_wait_max <= stat_clr ? '0 : wait_cnt > cpu_wait_max ? wait_cnt : cpu_wait_max;
    end
  end
  vga_cfg_shadow #(.DIM_W(DIM_W), .DEF_DIM(DEF_DIM)) u_cfg (
    .clk(clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .cfg_load(cfg_load),
    .cfg_dim(cfg_dim),
    .cfg_interp(cfg_interp),
    .dim_out(dim_out),
    .interp_out(interp_out),
    .cfg_pending(cfg_pending)
  );
endmodule

// File: doc/vga_frame_ctrl.md
Name: vga_frame_ctrl

Overview:
- Controller between the VGA timing/address path (the Vga_address block) and the single-port synchronous image RAM.
- Arbitrates each RAM cycle between the VGA pixel fetch and the processor/interpolation master.
- Supplies Vga_address with its active configuration (dimensiones, interpolacion), changed only at frame boundaries so no frame tears mid-scan.

Parameters:
ADDR_W, 19, RAM address width (matches DataAdr_out).
DATA_W, 8, pixel/RAM data width.
DIM_W, 16, width of dimensiones.
DEF_DIM, 400, dimensiones value loaded at reset.
WAIT_W, 8, width of CPU wait counters (saturating).

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
frame_start  in  1  one-cycle pulse at start of vertical blanking
cfg_load  in  1  one-cycle pulse: capture cfg_dim/cfg_interp as pending
cfg_dim  in  DIM_W  requested dimensiones
cfg_interp  in  1  requested interpolacion
dim_out  out  DIM_W  active dimensiones to Vga_address
interp_out  out  1  active interpolacion to Vga_address
cfg_pending  out  1  pending config not yet committed
vga_en  in  1  enable_pixel from Vga_address
vga_addr  in  ADDR_W  DataAdr_out from Vga_address
vga_rdata  out  DATA_W  pixel data
vga_rvalid  out  1  vga_rdata valid
cpu_req  in  1  CPU access request (held until cpu_gnt)
cpu_we  in  1  1 = write
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  access performed this cycle
cpu_rdata  out  DATA_W  CPU read data
cpu_rvalid  out  1  cpu_rdata valid
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, 1 cycle after address
stat_clr  in  1  clear wait statistics
cpu_wait_max  out  WAIT_W  longest CPU wait seen (cycles)

Behaviour:
Reset (rst_n low at posedge):
- dim_out=DEF_DIM, interp_out=0, cfg_pending=0.
- vga_rvalid=0, cpu_rvalid=0; wait counters = 0; any in-flight read is discarded.

Arbitration (combinational grant, strict VGA priority):
- vga_en=1: mem_addr=vga_addr, mem_we=0, cpu_gnt=0.
- else cpu_req=1: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata, cpu_gnt=1.
- else: mem_we=0, mem_addr holds its last value.
- mem_we is never 1 while vga_en=1.

Read return:
- vga_rvalid registered: equals previous-cycle vga_en; cpu_rvalid = previous-cycle (cpu_gnt & !cpu_we).
- vga_rdata and cpu_rdata are driven from mem_rdata; each is valid only while its rvalid is high.
- Read latency 1 cycle after grant. Writes give no rvalid.

CPU handshake:
- CPU holds cpu_req/cpu_we/cpu_addr/cpu_wdata stable until the cycle cpu_gnt=1.
- May drop cpu_req or change request the cycle after grant.
- Back-to-back CPU grants are allowed every free cycle.

Wait statistics:
- wait_cnt increments (saturating at 2^WAIT_W-1) each cycle cpu_req=1 and cpu_gnt=0.
- Clears on a cycle with cpu_gnt=1, or with cpu_req=0.
- cpu_wait_max <= max(cpu_wait_max, wait_cnt) every cycle.
- stat_clr zeroes both; stat_clr takes precedence over update.

Config FSM, states ACTIVE and PENDING:
- ACTIVE, cfg_load: pend regs <= cfg_*, go PENDING.
- PENDING, frame_start: dim_out/interp_out <= pend, go ACTIVE.
- PENDING, cfg_load without frame_start: pend overwritten (last write wins).
- PENDING, cfg_load and frame_start in the same cycle: commit old pend, capture new cfg into pend, stay PENDING.
- ACTIVE, cfg_load and frame_start in the same cycle: capture only; commit at the next frame_start.
- cfg_pending = (state==PENDING).
- Active outputs never change except on frame_start or reset.

Decomposition:
- Package vga_pkg: ADDR_W/DATA_W/DIM_W defaults, DEF_DIM, typedef enum {CFG_ACTIVE, CFG_PENDING} cfg_state_t.
- One natural sub-module: vga_cfg_shadow (config FSM plus pend/active registers).
- Arbiter and statistics stay in the top.

Test Plan:
1. Reset, then idle -> dim_out=400, interp_out=0, cfg_pending=0, both rvalid=0, cpu_wait_max=0.
2. cpu_req read addr 0x00100 with vga_en=0 -> cpu_gnt same cycle, mem_addr=0x00100, cpu_rvalid next cycle with RAM model data; then write 0xA5 to 0x00100 -> mem_we=1, no rvalid; read back returns 0xA5.
3. vga_en=1 for 20 cycles while cpu_req write held -> mem_we=0 throughout, cpu_gnt on first cycle vga_en=0, cpu_wait_max=20; vga_rvalid tracks vga_en delayed 1.
4. cfg_load dim=300 mid-frame -> dim_out stays 400, cfg_pending=1; on frame_start dim_out=300 next cycle, cfg_pending=0.
5. In PENDING(300), cfg_load dim=250 together with frame_start -> dim_out=300, pending stays 1; next frame_start -> dim_out=250.
6. rst_n low while a CPU read is in flight and pending cfg=300 -> next cycle cpu_rvalid=0, dim_out=400, cfg_pending=0; wait counter saturates at 255 after 300 blocked cycles.
